// File: rtl/im_boot_loader.sv
// Byte-stream boot loader: assembles little-endian 32-bit words into instruction memory
// and holds the CPU in reset until a length-framed, checksum-verified image has arrived.
module im_boot_loader #(
   parameter int ADDR_WIDTH = 7
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   output logic                  rx_ready,
   input  logic                  reload,
   output logic                  im_we,
   output logic [ADDR_WIDTH-1:0] im_addr,
   output logic [31:0]           im_wdata,
   output logic                  cpu_rstn,
   output logic                  load_done,
   output logic                  load_err,
   output logic [15:0]           word_cnt
);

   typedef enum logic [2:0] {
      S_LEN_LO,
      S_LEN_HI,
      S_DATA,
      S_CSUM,
      S_DONE,
      S_ERR
   } state_t;

   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

   state_t                state_q, state_d;
   logic [1:0]            idx_q, idx_d;
   logic [7:0]            acc_q, acc_d;
   logic [15:0]           len_q, len_d;
   logic [23:0]           buf_q, buf_d;
   logic                  im_we_q, im_we_d;
   logic [ADDR_WIDTH-1:0] im_addr_q, im_addr_d;
   logic [31:0]           im_wdata_q, im_wdata_d;
   logic [15:0]           word_cnt_q, word_cnt_d;
   logic                  load_done_q, load_done_d;
   logic                  load_err_q, load_err_d;
   logic                  cpu_rstn_q, cpu_rstn_d;
   logic                  accept;
   logic [15:0]           n_len;
   logic [15:0]           cnt_inc;

   function automatic logic [7:0] csum_add(input logic [7:0] a, input logic [7:0] b);
      return a + b;
   endfunction

   // Ready depends only on state; gating with rstn keeps it low while reset is held.
   always_comb begin
      rx_ready = 1'b0;
      if (rstn) begin
         case (state_q)
            S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM: rx_ready = 1'b1;
            default:                            rx_ready = 1'b0;
         endcase
      end
   end

   assign accept  = rx_valid && rx_ready;
   assign n_len   = {rx_data, len_q[7:0]};
   assign cnt_inc = word_cnt_q + 16'd1;

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      acc_d      = acc_q;
      len_d      = len_q;
      buf_d      = buf_q;
      im_we_d    = 1'b0;
      im_addr_d  = im_addr_q;
      im_wdata_d = im_wdata_q;
      word_cnt_d = word_cnt_q;

      case (state_q)
         S_LEN_LO: begin
            if (accept) begin
               len_d   = {8'h00, rx_data};
               state_d = S_LEN_HI;
            end
         end
         S_LEN_HI: begin
            if (accept) begin
               len_d = n_len;
               idx_d = 2'd0;
               if (32'(n_len) > DEPTH)  state_d = S_ERR;
               else if (n_len == 16'd0) state_d = S_CSUM;
               else                     state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (accept) begin
               acc_d = csum_add(acc_q, rx_data);
               idx_d = idx_q + 2'd1;
               case (idx_q)
                  2'd0: buf_d[7:0]   = rx_data;
                  2'd1: buf_d[15:8]  = rx_data;
                  2'd2: buf_d[23:16] = rx_data;
                  default: begin
                     // Fourth byte completes the word; address is the pre-increment count.
                     im_we_d    = 1'b1;
                     im_addr_d  = word_cnt_q[ADDR_WIDTH-1:0];
                     im_wdata_d = {rx_data, buf_q};
                     word_cnt_d = cnt_inc;
                     if (cnt_inc == len_q) state_d = S_CSUM;
                  end
               endcase
            end
         end
         S_CSUM: begin
            if (accept) state_d = (rx_data == acc_q) ? S_DONE : S_ERR;
         end
         S_DONE, S_ERR: begin
            if (reload) begin
               state_d    = S_LEN_LO;
               acc_d      = 8'h00;
               idx_d      = 2'd0;
               len_d      = 16'h0000;
               word_cnt_d = 16'h0000;
            end
         end
         default: state_d = S_LEN_LO;
      endcase

      load_done_d = (state_d == S_DONE);
      cpu_rstn_d  = (state_d == S_DONE);
      load_err_d  = (state_d == S_ERR);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= S_LEN_LO;
         idx_q       <= 2'd0;
         acc_q       <= 8'h00;
         len_q       <= 16'h0000;
         buf_q       <= 24'h000000;
         im_we_q     <= 1'b0;
         im_addr_q   <= '0;
         im_wdata_q  <= 32'h0000_0000;
         word_cnt_q  <= 16'h0000;
         load_done_q <= 1'b0;
         load_err_q  <= 1'b0;
         cpu_rstn_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         acc_q       <= acc_d;
         len_q       <= len_d;
         buf_q       <= buf_d;
         im_we_q     <= im_we_d;
         im_addr_q   <= im_addr_d;
         im_wdata_q  <= im_wdata_d;
         word_cnt_q  <= word_cnt_d;
         load_done_q <= load_done_d;
         load_err_q  <= load_err_d;
         cpu_rstn_q  <= cpu_rstn_d;
      end
   end

   assign im_we     = im_we_q;
   assign im_addr   = im_addr_q;
   assign im_wdata  = im_wdata_q;
   assign word_cnt  = word_cnt_q;
   assign load_done = load_done_q;
   assign load_err  = load_err_q;
   assign cpu_rstn  = cpu_rstn_q;

endmodule

// File: doc/im_boot_loader.md
Name: im_boot_loader

Overview:
- Upstream feeder for the single-cycle computer's instruction memory.
- Receives a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes each word into the instruction ROM and holds the CPU in reset until a complete, checksum-verified image is loaded.
- Replaces file-based ROM preload for hardware bring-up.

Parameters:
ADDR_WIDTH, 7, instruction-memory word-address width; depth = 2**ADDR_WIDTH words (128)

Ports:
clk  in  1  system clock, all state on rising edge
rstn  in  1  asynchronous active-low reset
rx_data  in  8  incoming byte
rx_valid  in  1  rx_data valid this cycle
rx_ready  out  1  loader accepts a byte this cycle
reload  in  1  single-cycle request to restart loading (honoured only in DONE/ERR)
im_we  out  1  instruction-memory write strobe, one cycle per word
im_addr  out  ADDR_WIDTH  word address of the write
im_wdata  out  32  word to write
cpu_rstn  out  1  reset to the CPU, active-low; 1 only in DONE
load_done  out  1  image loaded and verified
load_err  out  1  length or checksum error
word_cnt  out  16  words written since the last (re)start

Behaviour:
- Frame format: LEN_LO, LEN_HI (N, 16-bit little-endian word count), then 4*N data bytes (each word LSB first), then CSUM.
- CSUM = 8-bit sum mod 256 of the data bytes only.
- A byte is accepted on a rising edge where rx_valid && rx_ready.
- States: S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_DONE, S_ERR.
- Reset (async, rstn=0):
  - state=S_LEN_LO; all outputs driven to 0.
  - Includes cpu_rstn=0, im_we=0, im_addr=0, im_wdata=0, word_cnt=0.
  - Internal byte index, checksum accumulator and N cleared.
  - Reset mid-frame discards the partial image; no im_we may be emitted after rstn falls.
- rx_ready=1 in S_LEN_LO, S_LEN_HI, S_DATA and S_CSUM; 0 in S_DONE and S_ERR. rx_ready is a function of state only, never of rx_valid.
- S_LEN_LO: on accept, latch the low byte → S_LEN_HI.
- S_LEN_HI: on accept, form N; then:
  - N > 2**ADDR_WIDTH → S_ERR.
  - N == 0 → S_CSUM.
  - Otherwise → S_DATA.
- S_DATA:
  - Each accepted byte is added to the accumulator and shifted into the word buffer (byte k → bits 8k+7:8k); byte index wraps 3→0.
  - On the 4th byte, im_we=1 on the next cycle for exactly one cycle, with im_addr = word_cnt[ADDR_WIDTH-1:0] and im_wdata = assembled word.
  - word_cnt increments in the same cycle im_we is high.
  - Write latency: one cycle after the 4th byte is accepted. Byte acceptance continues in the im_we cycle (no bubble).
  - After the N-th word's 4th byte → S_CSUM.
- S_CSUM: on accept, compare with the accumulator. Equal → S_DONE; unequal → S_ERR.
- S_DONE: load_done=1 and cpu_rstn=1, both registered, asserted the cycle after the CSUM byte is accepted.
- S_ERR: load_err=1 and cpu_rstn=0.
- reload=1 in S_DONE or S_ERR:
  - Next cycle → S_LEN_LO, with cpu_rstn=0, load_done=0, load_err=0, word_cnt=0 and accumulator cleared.
  - ROM contents are not cleared.
  - reload in any other state is ignored.
- Simultaneous reload and rx_valid in S_DONE/S_ERR: the byte is not accepted (rx_ready=0 that cycle).
- N == 2**ADDR_WIDTH is legal: the last word writes im_addr = all ones and word_cnt reaches 2**ADDR_WIDTH.
- rx_valid may drop between bytes at any point; state holds with no timeout.
- Checksum and byte-assembly arithmetic are 8-bit wrap-around; word_cnt is 16-bit.

Test Plan:
- Nominal load: stream 02 00 93 00 50 00 13 01 10 00 07 with rx_valid continuously high → im_we at addr 0 with 0x00500093, one cycle after the 4th data byte; im_we at addr 1 with 0x00100113; load_done=1, cpu_rstn=1, word_cnt=2, load_err=0.
- Bad checksum: same stream with final byte 08 → no change to the two writes; load_err=1, cpu_rstn=0, load_done=0; rx_ready=0 afterwards.
- Length overflow: 81 00 (N=129 with ADDR_WIDTH=7) → S_ERR immediately after the LEN_HI accept; zero im_we pulses; load_err=1.
- Gapped stream and zero length:
  - Nominal stream with rx_valid toggling 1/0 each cycle → identical writes and final state to the nominal load.
  - Frame 00 00 00 → load_done=1 with word_cnt=0 and no writes.
- Reset mid-operation: assert rstn=0 after 6 data bytes → all outputs 0 asynchronously, no further im_we. Then send the nominal stream → completes as in the nominal load.
- Reload: after DONE, pulse reload together with rx_valid=1 → that byte is not accepted; cpu_rstn drops to 0 the next cycle; load_done=0; a second nominal frame completes; reload pulsed outside DONE/ERR has no effect.
